// File: rtl/rf_write_arbiter.sv
// Two-requester register-file write arbiter: each requester feeds its own FIFO, and the
// heads are drained one per cycle into a registered rf write port with alternating priority.
module rf_write_arbiter #(
  parameter int unsigned DW    = 16,
  parameter int unsigned DEPTH = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          a_valid,
  input  logic [1:0]    a_addr,
  input  logic [DW-1:0] a_data,
  output logic          a_ready,
  input  logic          b_valid,
  input  logic [1:0]    b_addr,
  input  logic [DW-1:0] b_data,
  output logic          b_ready,
  output logic          rf_write,
  output logic [1:0]    rf_addr,
  output logic [DW-1:0] rf_data,
  output logic [3:0]    pending
);

  localparam int unsigned PW = $clog2(DEPTH);

  typedef logic [PW-1:0] ptr_t;
  typedef logic [PW:0]   cnt_t;
  typedef enum logic {GntA, GntB} grant_e;

  logic [1:0]    a_addr_mem [DEPTH];
  logic [DW-1:0] a_data_mem [DEPTH];
  logic [1:0]    b_addr_mem [DEPTH];
  logic [DW-1:0] b_data_mem [DEPTH];

  ptr_t   a_wr_q, a_rd_q, b_wr_q, b_rd_q;
  cnt_t   a_cnt_q, b_cnt_q;
  grant_e last_grant_q;

  logic a_push, a_pop, b_push, b_pop;
  logic a_nonempty, b_nonempty;

  // Ready is derived from the registered count only, so a same-cycle pop never frees a slot.
  assign a_ready    = (a_cnt_q != cnt_t'(DEPTH));
  assign b_ready    = (b_cnt_q != cnt_t'(DEPTH));
  assign a_push     = a_valid && a_ready;
  assign b_push     = b_valid && b_ready;
  assign a_nonempty = (a_cnt_q != '0);
  assign b_nonempty = (b_cnt_q != '0);

  always_comb begin
    a_pop = 1'b0;
    b_pop = 1'b0;
    if (a_nonempty && b_nonempty) begin
      if (last_grant_q == GntB) a_pop = 1'b1;
      else                      b_pop = 1'b1;
    end else if (a_nonempty) begin
      a_pop = 1'b1;
    end else if (b_nonempty) begin
      b_pop = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (a_push) begin
      a_addr_mem[a_wr_q] <= a_addr;
      a_data_mem[a_wr_q] <= a_data;
    end
    if (b_push) begin
      b_addr_mem[b_wr_q] <= b_addr;
      b_data_mem[b_wr_q] <= b_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      a_wr_q  <= '0;
      a_rd_q  <= '0;
      a_cnt_q <= '0;
      b_wr_q  <= '0;
      b_rd_q  <= '0;
      b_cnt_q <= '0;
    end else begin
      if (a_push) a_wr_q <= a_wr_q + ptr_t'(1);
      if (a_pop)  a_rd_q <= a_rd_q + ptr_t'(1);
      if (b_push) b_wr_q <= b_wr_q + ptr_t'(1);
      if (b_pop)  b_rd_q <= b_rd_q + ptr_t'(1);
      a_cnt_q <= a_cnt_q + cnt_t'(a_push) - cnt_t'(a_pop);
      b_cnt_q <= b_cnt_q + cnt_t'(b_push) - cnt_t'(b_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rf_write     <= 1'b0;
      rf_addr      <= '0;
      rf_data      <= '0;
      last_grant_q <= GntB;
    end else begin
      rf_write <= a_pop || b_pop;
      if (a_pop) begin
        rf_addr      <= a_addr_mem[a_rd_q];
        rf_data      <= a_data_mem[a_rd_q];
        last_grant_q <= GntA;
      end else if (b_pop) begin
        rf_addr      <= b_addr_mem[b_rd_q];
        rf_data      <= b_data_mem[b_rd_q];
        last_grant_q <= GntB;
      end
    end
  end

  // A slot is live when its distance from the read pointer is below the occupancy count.
  ptr_t a_off, b_off, idx;

  always_comb begin
    pending = '0;
    a_off   = '0;
    b_off   = '0;
    idx     = '0;
    for (int unsigned j = 0; j < DEPTH; j++) begin
      idx   = ptr_t'(j);
      a_off = idx - a_rd_q;
      b_off = idx - b_rd_q;
      if (cnt_t'(a_off) < a_cnt_q) pending[a_addr_mem[idx]] = 1'b1;
      if (cnt_t'(b_off) < b_cnt_q) pending[b_addr_mem[idx]] = 1'b1;
    end
    if (rf_write) pending[rf_addr] = 1'b1;
  end

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Scoreboard bench for rf_write_arbiter: a queue-based reference model predicts every rf write,
// ready and pending value; directed scenarios additionally check ordering and timing of writes.
module tb_rf_write_arbiter;

  localparam int unsigned DW    = 16;
  localparam int unsigned DEPTH = 2;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          a_valid = 1'b0, b_valid = 1'b0;
  logic [1:0]    a_addr = '0, b_addr = '0;
  logic [DW-1:0] a_data = '0, b_data = '0;
  logic          a_ready, b_ready, rf_write;
  logic [1:0]    rf_addr;
  logic [DW-1:0] rf_data;
  logic [3:0]    pending;

  always #5 clk = ~clk;

  rf_write_arbiter #(.DW(DW), .DEPTH(DEPTH)) dut (
    .clk      (clk),
    .reset    (reset),
    .a_valid  (a_valid),
    .a_addr   (a_addr),
    .a_data   (a_data),
    .a_ready  (a_ready),
    .b_valid  (b_valid),
    .b_addr   (b_addr),
    .b_data   (b_data),
    .b_ready  (b_ready),
    .rf_write (rf_write),
    .rf_addr  (rf_addr),
    .rf_data  (rf_data),
    .pending  (pending)
  );

  typedef struct packed {logic [1:0] addr; logic [DW-1:0] data;} ent_t;
  typedef struct {int cyc; logic [1:0] addr; logic [DW-1:0] data;} obs_t;

  int   n_vec = 0, n_err = 0, cyc = 0;
  ent_t ma[$], mb[$], exp_q[$];
  obs_t obs[$];
  logic m_last_b = 1'b1, m_wr = 1'b0;
  ent_t m_rf = '0, e;
  logic [3:0] m_pend;
  bit   mon_en = 0, ga, gb, acc_a, acc_b;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  // Compare DUT outputs against the model, then advance the model with the inputs the next
  // rising edge will sample (inputs only change just after a rising edge).
  initial forever begin
    @(negedge clk);
    cyc++;
    if (mon_en) begin
      check_eq("rf_write", rf_write, m_wr);
      if (rf_write) begin
        if (exp_q.size() == 0) begin
          check_eq("rf_unexpected", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check_eq("rf_addr", rf_addr, e.addr);
          check_eq("rf_data", rf_data, e.data);
        end
        obs.push_back('{cyc, rf_addr, rf_data});
      end else begin
        check_eq("rf_addr_hold", rf_addr, m_rf.addr);
        check_eq("rf_data_hold", rf_data, m_rf.data);
      end
      m_pend = '0;
      foreach (ma[i]) m_pend[ma[i].addr] = 1'b1;
      foreach (mb[i]) m_pend[mb[i].addr] = 1'b1;
      if (m_wr) m_pend[m_rf.addr] = 1'b1;
      check_eq("pending", pending, m_pend);
      check_eq("a_ready", a_ready, ma.size() < int'(DEPTH));
      check_eq("b_ready", b_ready, mb.size() < int'(DEPTH));
    end
    if (reset) begin
      ma.delete();
      mb.delete();
      exp_q.delete();
      m_last_b = 1'b1;
      m_wr     = 1'b0;
      m_rf     = '0;
      mon_en   = 1;
    end else begin
      acc_a = a_valid && (ma.size() < int'(DEPTH));
      acc_b = b_valid && (mb.size() < int'(DEPTH));
      ga = 0;
      gb = 0;
      if (ma.size() > 0 && mb.size() > 0) begin
        if (m_last_b) ga = 1;
        else          gb = 1;
      end else if (ma.size() > 0) begin
        ga = 1;
      end else if (mb.size() > 0) begin
        gb = 1;
      end
      m_wr = ga || gb;
      if (ga) begin m_rf = ma.pop_front(); m_last_b = 1'b0; end
      if (gb) begin m_rf = mb.pop_front(); m_last_b = 1'b1; end
      if (m_wr) exp_q.push_back(m_rf);
      if (acc_a) ma.push_back({a_addr, a_data});
      if (acc_b) mb.push_back({b_addr, b_data});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic push(input bit side_b, input logic [1:0] addr, input logic [DW-1:0] data);
    int guard = 0;
    bit took = 0;
    if (side_b) begin b_valid = 1'b1; b_addr = addr; b_data = data; end
    else        begin a_valid = 1'b1; a_addr = addr; a_data = data; end
    do begin
      took = side_b ? b_ready : a_ready;
      tick();
      guard++;
    end while (!took && guard < 50);
    if (!took) check_eq(side_b ? "b_accept_timeout" : "a_accept_timeout", 0, 1);
    if (side_b) b_valid = 1'b0;
    else        a_valid = 1'b0;
  endtask

  int n0;

  initial begin
    idle(2);
    reset = 1'b0;
    check_eq("rst_rf_write", rf_write, 0);
    check_eq("rst_pending", pending, 0);
    check_eq("rst_a_ready", a_ready, 1);
    check_eq("rst_b_ready", b_ready, 1);

    // Single write to r2.
    n0 = obs.size();
    push(0, 2'd2, 16'h1234);
    idle(4);
    check_eq("single_count", obs.size() - n0, 1);
    if (obs.size() > n0) begin
      check_eq("single_addr", obs[n0].addr, 2);
      check_eq("single_data", obs[n0].data, 16'h1234);
    end

    // Same-edge contention straight after reset: A first, B on the next cycle.
    do_reset();
    n0 = obs.size();
    a_valid = 1'b1; a_addr = 2'd1; a_data = 16'h00AA;
    b_valid = 1'b1; b_addr = 2'd3; b_data = 16'h00BB;
    tick();
    a_valid = 1'b0;
    b_valid = 1'b0;
    idle(4);
    check_eq("contend_count", obs.size() - n0, 2);
    if (obs.size() > n0 + 1) begin
      check_eq("contend_first", obs[n0].data, 16'h00AA);
      check_eq("contend_second", obs[n0+1].data, 16'h00BB);
      check_eq("contend_back2back", obs[n0+1].cyc - obs[n0].cyc, 1);
    end

    // Continuous streams from both sides fill the FIFOs and must alternate.
    do_reset();
    n0 = obs.size();
    fork
      begin for (int i = 0; i < 4; i++) push(0, 2'd0, DW'(32'hA000 + i)); end
      begin for (int i = 0; i < 4; i++) push(1, 2'd1, DW'(32'hB000 + i)); end
    join
    idle(6);
    check_eq("alt_count", obs.size() - n0, 8);
    for (int i = 0; i < 8; i++) begin
      if (obs.size() > n0 + i)
        check_eq("alt_order", obs[n0+i].data,
                 (i % 2 == 0) ? 32'hA000 + i / 2 : 32'hB000 + i / 2);
    end

    // Five writes to r0 from A alone: back-to-back with pointer wrap.
    do_reset();
    n0 = obs.size();
    for (int i = 1; i <= 5; i++) push(0, 2'd0, DW'(i));
    idle(4);
    check_eq("wrap_count", obs.size() - n0, 5);
    for (int i = 0; i < 5; i++) begin
      if (obs.size() > n0 + i) begin
        check_eq("wrap_data", obs[n0+i].data, i + 1);
        check_eq("wrap_cycle", obs[n0+i].cyc - obs[n0].cyc, i);
      end
    end

    // Queue entries then reset: nothing queued may reach the rf port afterwards.
    fork
      begin for (int i = 0; i < 3; i++) push(0, 2'd1, DW'(32'hC000 + i)); end
      begin for (int i = 0; i < 2; i++) push(1, 2'd2, DW'(32'hD000 + i)); end
    join
    do_reset();
    n0 = obs.size();
    check_eq("rstmid_rf_write", rf_write, 0);
    check_eq("rstmid_pending", pending, 0);
    check_eq("rstmid_a_ready", a_ready, 1);
    idle(4);
    check_eq("rstmid_no_writes", obs.size() - n0, 0);

    // B writes r2 on the port while A's r2 write is queued behind it.
    push(1, 2'd2, 16'h0B02);
    push(0, 2'd2, 16'h0A02);
    idle(4);

    // Random traffic with occasional reset.
    for (int i = 0; i < 400; i++) begin
      a_valid = 1'($urandom_range(0, 1));
      b_valid = 1'($urandom_range(0, 1));
      a_addr  = 2'($urandom);
      b_addr  = 2'($urandom);
      a_data  = DW'($urandom);
      b_data  = DW'($urandom);
      reset   = ($urandom_range(0, 63) == 0);
      tick();
    end
    a_valid = 1'b0;
    b_valid = 1'b0;
    reset   = 1'b0;
    idle(6);
    check_eq("sb_drain", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/rf_write_arbiter.md
RF_WRITE_ARBITER -- requirements
Module: rf_write_arbiter

Interface
REQ-001 Parameter: DW, 16, data width of each write request and of rf_data.
REQ-002 Parameter: DEPTH, 2, entries per requester queue (power of two, >=2).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset; sampled on rising edge of clk.
REQ-005 a_valid  input  1  requester A write request.
REQ-006 a_addr  input  2  requester A destination register.
REQ-007 a_data  input  DW  requester A write data.
REQ-008 a_ready  output  1  requester A queue can accept.
REQ-009 b_valid, b_addr, b_data, b_ready  as REQ-005..008, for requester B.
REQ-010 rf_write  output  1  register-file write enable, registered.
REQ-011 rf_addr  output  2  register-file write address, registered.
REQ-012 rf_data  output  DW  register-file write data, registered.
REQ-013 pending  output  4  bit i high while any write to register i is queued or on the rf port.

Function
REQ-014 Each requester SHALL feed its own FIFO of DEPTH entries holding {addr, data}.
REQ-015 Accept on A SHALL occur at a rising edge where a_valid && a_ready; same for B.
REQ-016 a_ready SHALL equal "A FIFO not full", from registered count only; no dependence on same-cycle pop or on a_valid.
REQ-017 Arbiter SHALL pop at most one FIFO head per cycle and load it into the rf output register.
REQ-018 Only A non-empty -> grant A; only B non-empty -> grant B; both empty -> no grant, rf_write=0 next cycle.
REQ-019 Both non-empty -> grant the requester not granted last; last_grant updates only on an actual grant.
REQ-020 After reset, last_grant SHALL equal B, so first contended grant goes to A.
REQ-021 Latency: request accepted at edge t SHALL appear as rf_write=1 in the cycle after edge t+1, with no contention and an empty FIFO ahead of it.
REQ-022 rf_write SHALL be high for exactly one cycle per granted entry; rf_addr/rf_data hold the last granted value when rf_write=0.
REQ-023 Per-requester order SHALL be preserved; no ordering between A and B beyond REQ-019.
REQ-024 Push and pop on the same FIFO in the same cycle SHALL be allowed when not full; count unchanged.
REQ-025 Full FIFO: valid held high with ready=0 SHALL not alter the FIFO; entry is taken on the first edge with ready=1.
REQ-026 Pointers SHALL wrap modulo DEPTH without loss or duplication.
REQ-027 pending SHALL be combinational OR over valid entries of both FIFOs plus the rf output register when rf_write=1.
REQ-028 A write entering a FIFO SHALL set its pending bit in the cycle after the accept edge; the bit SHALL clear in the cycle after its rf_write cycle, unless another entry targets the same register.

Reset
REQ-029 With reset high at an edge: both FIFOs empty, pointers/counts 0, rf_write=0, rf_addr=0, rf_data=0, last_grant=B, pending=0.
REQ-030 Reset mid-operation SHALL drop all queued entries; requests offered in the reset cycle SHALL not be accepted.
REQ-031 a_ready and b_ready SHALL be 1 in the first cycle after reset deasserts.

Verification
REQ-032 Single A write addr=2 data=16'h1234 at edge t -> rf_write=1, rf_addr=2, rf_data=16'h1234 after edge t+1 only; pending=4'b0100 over those two cycles, then 0.
REQ-033 A and B accepted same edge (A: r1 16'h00AA, B: r3 16'h00BB) after reset -> A written first, B next cycle; rf_write high two consecutive cycles.
REQ-034 A and B each push 4 entries continuously, DEPTH=2 -> rf writes strictly alternate A,B,...; a_ready/b_ready drop when full; all 8 writes seen in per-requester order.
REQ-035 A pushes 5 entries to r0 with data 1..5, B idle -> rf_data sequence 1,2,3,4,5 on consecutive cycles after fill, with pointer wrap; pending[0] high throughout, then clears.
REQ-036 Two entries queued in A, reset asserted one cycle -> next cycle rf_write=0, pending=0, a_ready=1; no queued write ever reaches the rf port.
REQ-037 A requests while rf port emits B's write to the same register r2 -> pending[2] stays high continuously until A's write completes.
